// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data-memory responder
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_BUSY,
    DMEM_RESP
  } dmem_state_t;

  typedef struct packed {
    logic        write;
    mem_size_t   size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Size code 11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return MEM_BYTE;
      2'b01:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian byte/half/word store merge, load extract and misalign detect
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        sign_ext,
  output logic [31:0] new_word,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane; half accesses only look at offset[1].
  assign byte_sh = 5'd24 - {offset, 3'b000};
  assign half_sh = offset[1] ? 5'd0 : 5'd16;
  assign byte_v  = 8'(old_word >> byte_sh);
  assign half_v  = 16'(old_word >> half_sh);

  always_comb begin
    new_word   = old_word;
    rdata      = old_word;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        new_word = (old_word & ~(32'h0000_00ff << byte_sh)) | ({24'h0, wdata[7:0]} << byte_sh);
        rdata    = sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      MEM_HALF: begin
        new_word   = (old_word & ~(32'h0000_ffff << half_sh)) | ({16'h0, wdata[15:0]} << half_sh);
        rdata      = sign_ext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        misaligned = offset[0];
      end
      default: begin
        new_word   = wdata;
        rdata      = old_word;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data RAM responder with wait states and pipeline stall
// Optional DMEM_ERR_EN: suppress misaligned accesses and report them on misaligned_err.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall
`ifdef DMEM_ERR_EN
  ,
  output logic        misaligned_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmem_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  dmem_req_t             in_req, cur_req;
  logic [31:0]           rdata_q, rdata_d;
  logic                  suppress;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           old_word, new_word, lane_rdata;
  logic                  mis_det;
  logic                  unused_addr;

  // Storage survives rst_n; it is only zeroed at time 0.
  logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

  always_comb begin
    in_req.write    = req_write;
    in_req.size     = decode_size(req_size);
    in_req.sign_ext = req_signed;
    in_req.addr     = req_addr;
    in_req.wdata    = req_wdata;
  end

  // With no wait states the commit happens on the accepting edge, before req_q is loaded.
  assign cur_req     = (state_q == DMEM_IDLE) ? in_req : req_q;
  assign word_idx    = cur_req.addr[ADDR_WIDTH+OFF_W-1:OFF_W];
  assign old_word    = mem_q[word_idx];
  assign unused_addr = ^cur_req.addr[31:ADDR_WIDTH+OFF_W];

  dmem_lane_align u_lane_align (
    .old_word   (old_word),
    .wdata      (cur_req.wdata),
    .offset     (cur_req.addr[1:0]),
    .size       (cur_req.size),
    .sign_ext   (cur_req.sign_ext),
    .new_word   (new_word),
    .rdata      (lane_rdata),
    .misaligned (mis_det)
  );

`ifdef DMEM_ERR_EN
  logic err_q, err_d;
  assign suppress       = mis_det;
  assign misaligned_err = err_q;
`else
  logic unused_mis;
  assign suppress   = 1'b0;
  assign unused_mis = mis_det;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
`ifdef DMEM_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      DMEM_IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DMEM_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = DMEM_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    if (state_d == DMEM_RESP) begin
      rdata_d = (cur_req.write || suppress) ? 32'h0 : lane_rdata;
`ifdef DMEM_ERR_EN
      err_d   = suppress;
`endif
    end
  end

  assign mem_we = rst_n && (state_d == DMEM_RESP) && cur_req.write && !suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
`ifdef DMEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= new_word;
    end
  end

  assign req_ready  = (state_q == DMEM_IDLE);
  assign resp_valid = (state_q == DMEM_RESP);
  assign resp_rdata = rdata_q;
  assign stall      = ((state_q == DMEM_IDLE) && req_valid) || (state_q == DMEM_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES 2 and 0 instances)
module tb_dmem_responder;

  localparam int WAIT_A = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req_valid, a_req_write, a_req_signed;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [1:0]  a_req_size;
  logic        a_req_ready, a_resp_valid, a_stall;
  logic [31:0] a_resp_rdata;
  logic        b_req_valid, b_req_write, b_req_signed;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_req_ready, b_resp_valid, b_stall;
  logic [31:0] b_resp_rdata;
`ifdef DMEM_ERR_EN
  logic        a_err, b_err;
`endif

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_size(a_req_size), .req_signed(a_req_signed),
    .req_wdata(a_req_wdata), .req_ready(a_req_ready), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .stall(a_stall)
`ifdef DMEM_ERR_EN
    , .misaligned_err(a_err)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_size(b_req_size), .req_signed(b_req_signed),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .stall(b_stall)
`ifdef DMEM_ERR_EN
    , .misaligned_err(b_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (a_resp_valid) begin
      check("resp_expected", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("resp_rdata", a_resp_rdata, e.rdata);
`ifdef DMEM_ERR_EN
        check("misaligned_err", a_err, e.err);
`endif
      end
    end
  end

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    exp_t x;
    int lat;
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
    a_req_size = size;  a_req_signed = sgn; a_req_wdata = wdata;
    x.rdata = exp_rdata; x.err = exp_err;
    sb_q.push_back(x);
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("stall", a_stall, (k <= WAIT_A) ? 32'd1 : 32'd0);
      check("req_ready", a_req_ready, (k == 0) ? 32'd1 : 32'd0);
      if (a_resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_req_wdata = 32'h5a5a_5a5a;
      a_req_addr  = 32'hffff_fffc;
    end
    check("latency", lat, WAIT_A + 1);
    @(negedge clk);
    check("rdata_hold", a_resp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_size = 0; a_req_signed = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_size = 0; b_req_signed = 0; b_req_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", a_req_ready, 1);
    check("rst_resp_valid", a_resp_valid, 0);
    check("rst_resp_rdata", a_resp_rdata, 0);
    check("rst_stall", a_stall, 0);
    check("rst_b_req_ready", b_req_ready, 1);
`ifdef DMEM_ERR_EN
    check("rst_err", a_err, 0);
`endif

    run_req(1, 32'h10, 2'b10, 0, 32'hdeadbeef, 32'h0, 0);
    run_req(0, 32'h10, 2'b10, 0, 32'h0, 32'hdeadbeef, 0);
    run_req(0, 32'h1010, 2'b11, 0, 32'h0, 32'hdeadbeef, 0);

    run_req(1, 32'h20, 2'b10, 0, 32'h80ff7f01, 32'h0, 0);
    run_req(0, 32'h20, 2'b00, 1, 32'h0, 32'hffffff80, 0);
    run_req(0, 32'h21, 2'b00, 0, 32'h0, 32'h000000ff, 0);
    run_req(0, 32'h22, 2'b01, 1, 32'h0, 32'h00007f01, 0);
    run_req(0, 32'h20, 2'b01, 0, 32'h0, 32'h000080ff, 0);

    run_req(1, 32'h40, 2'b10, 0, 32'ha5a5a5a5, 32'h0, 0);
    run_req(1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0, 0);
    run_req(1, 32'h23, 2'b00, 0, 32'hffffffab, 32'h0, 0);
    run_req(0, 32'h20, 2'b10, 0, 32'h0, 32'h112233ab, 0);
    run_req(1, 32'h20, 2'b01, 0, 32'h1234cafe, 32'h0, 0);
    run_req(0, 32'h20, 2'b10, 0, 32'h0, 32'hcafe33ab, 0);

    // Reset while a store sits in BUSY: store dropped, outputs cleared.
    @(posedge clk); #1;
    a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h40; a_req_size = 2'b10; a_req_wdata = 32'h12345678;
    @(posedge clk); #1;
    a_req_valid = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", a_req_ready, 1);
    check("midrst_resp_valid", a_resp_valid, 0);
    check("midrst_stall", a_stall, 0);
    check("midrst_rdata", a_resp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_req(0, 32'h40, 2'b10, 0, 32'h0, 32'ha5a5a5a5, 0);

    run_req(0, 32'h13, 2'b10, 0, 32'h0, ERR ? 32'h0 : 32'hdeadbeef, ERR);
    run_req(1, 32'h13, 2'b10, 0, 32'h0badf00d, 32'h0, ERR);
    run_req(0, 32'h10, 2'b10, 0, 32'h0, ERR ? 32'hdeadbeef : 32'h0badf00d, 0);

    // Zero-wait instance: store, then back-to-back loads held on req_valid.
    @(posedge clk); #1;
    b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h4; b_req_size = 2'b10; b_req_wdata = 32'h01020304;
    @(posedge clk); #1;
    b_req_valid = 0;
    @(negedge clk);
    check("b_store_resp", b_resp_valid, 1);
    @(posedge clk); #1;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_resp_valid", b_resp_valid, (k == 1 || k == 3) ? 32'd1 : 32'd0);
      check("b_req_ready", b_req_ready, (k == 1 || k == 3) ? 32'd0 : 32'd1);
      if (k == 1) check("b_rdata0", b_resp_rdata, 32'h0);
      if (k == 3) check("b_rdata1", b_resp_rdata, 32'h01020304);
      @(posedge clk); #1;
      if (k == 0) b_req_addr = 32'h4;
      if (k == 2) b_req_valid = 0;
    end

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
